// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Data wins ties until a bounded burst while a fetch waits, then fetch is served.
module mem_port_arbiter #(
  parameter int WIDTH       = 32,
  parameter int MAX_D_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_valid,
  output logic [WIDTH-1:0] d_rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             stall
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] MAX_B = 4'(MAX_D_BURST);

  state_t           state_q, state_d;
  logic [3:0]       dcnt_q, dcnt_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic             if_valid_q, if_valid_d;
  logic             d_valid_q, d_valid_d;
  logic [WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic             if_pend, d_pend;

  // A req seen alongside its own valid pulse is the tail of the finished access.
  assign if_pend = if_req & ~if_valid_q;
  assign d_pend  = d_req & ~d_valid_q;

  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (d_pend && (!if_pend || dcnt_q < MAX_B)) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          if (if_pend) begin
            dcnt_d = (dcnt_q < MAX_B) ? dcnt_q + 4'd1 : dcnt_q;
          end else begin
            dcnt_d = '0;
          end
        end else if (if_pend) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          dcnt_d      = '0;
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          if_valid_d = 1'b1;
          if_rdata_d = mem_rdata;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          d_valid_d = 1'b1;
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      dcnt_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign stall     = (if_req & ~if_valid_q) | (d_req & ~d_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level
// reference model with its own memory array.
module tb_mem_port_arbiter;
  localparam int W    = 32;
  localparam int MAXB = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [W-1:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic         if_valid, d_valid, mem_req, mem_we, stall;
  logic [W-1:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(W), .MAX_D_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(stall)
  );

  int total = 0, bad = 0, txn = 0;
  logic [W-1:0] mem_arr [0:255];

  // Reference model: who owns the memory, how long it has waited, burst tally.
  int           m_owner = 0;   // 0 none, 1 fetch, 2 data
  int           m_age = 0;
  int           m_burst = 0;
  logic         exp_mem_req = 0, exp_mem_we = 0, exp_if_valid = 0, exp_d_valid = 0;
  logic [W-1:0] exp_mem_addr = '0, exp_mem_wdata = '0, exp_if_rdata = '0, exp_d_rdata = '0;

  int rdy_mode = 3;            // 0 random, 1 always, 2 on Nth busy cycle, 3 never
  int rdy_n = 1;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_owner = 0; m_age = 0; m_burst = 0;
    exp_mem_req = 0; exp_mem_we = 0; exp_mem_addr = '0; exp_mem_wdata = '0;
    exp_if_valid = 0; exp_d_valid = 0; exp_if_rdata = '0; exp_d_rdata = '0;
  endtask

  task automatic model_next();
    bit if_p, d_p, nv_if, nv_d;
    if_p  = if_req && !exp_if_valid;
    d_p   = d_req && !exp_d_valid;
    nv_if = 0;
    nv_d  = 0;
    if (m_owner == 0) begin
      if (d_p && (!if_p || m_burst < MAXB)) begin
        m_owner = 2; m_age = 0;
        exp_mem_req = 1; exp_mem_we = d_we; exp_mem_addr = d_addr; exp_mem_wdata = d_wdata;
        m_burst = if_p ? ((m_burst < MAXB) ? m_burst + 1 : MAXB) : 0;
      end else if (if_p) begin
        m_owner = 1; m_age = 0;
        exp_mem_req = 1; exp_mem_we = 0; exp_mem_addr = if_addr; exp_mem_wdata = '0;
        m_burst = 0;
      end
    end else if (mem_ready) begin
      txn++;
      if (m_owner == 1) begin
        exp_if_rdata = mem_rdata;
        nv_if = 1;
        $display("txn %0d: fetch addr=%h data=%h", txn, exp_mem_addr, mem_rdata);
      end else begin
        nv_d = 1;
        if (exp_mem_we) begin
          mem_arr[exp_mem_addr[9:2]] = exp_mem_wdata;
          $display("txn %0d: store addr=%h data=%h", txn, exp_mem_addr, exp_mem_wdata);
        end else begin
          exp_d_rdata = mem_rdata;
          $display("txn %0d: load  addr=%h data=%h", txn, exp_mem_addr, mem_rdata);
        end
      end
      exp_mem_req = 0;
      m_owner = 0;
    end else begin
      m_age++;
    end
    exp_if_valid = nv_if;
    exp_d_valid  = nv_d;
  endtask

  // One clock: answer memory, check stall, advance model, check registered outputs.
  task automatic step();
    #1;
    case (rdy_mode)
      0:       mem_ready = ($urandom_range(0, 2) == 0);
      1:       mem_ready = 1'b1;
      2:       mem_ready = (m_owner != 0) && (m_age + 1 == rdy_n);
      default: mem_ready = 1'b0;
    endcase
    mem_rdata = mem_ready ? mem_arr[exp_mem_addr[9:2]] : W'($urandom);
    #1;
    chk("stall", stall, (if_req && !exp_if_valid) || (d_req && !exp_d_valid));
    if (rst) model_next();
    else m_reset();
    @(posedge clk);
    #1;
    chk("mem_req", mem_req, exp_mem_req);
    chk("mem_we", mem_we, exp_mem_we);
    chk("mem_addr", mem_addr, exp_mem_addr);
    chk("mem_wdata", mem_wdata, exp_mem_wdata);
    chk("if_valid", if_valid, exp_if_valid);
    chk("d_valid", d_valid, exp_d_valid);
    chk("if_rdata", if_rdata, exp_if_rdata);
    chk("d_rdata", d_rdata, exp_d_rdata);
  endtask

  task automatic rand_agents();
    if (!if_req || exp_if_valid) begin
      if (!if_req || exp_if_valid) if_req = ($urandom_range(0, 3) != 0);
      if_addr = W'($urandom_range(0, 255)) << 2;
    end
    if (!d_req || exp_d_valid) begin
      d_req   = ($urandom_range(0, 2) != 0);
      d_we    = $urandom_range(0, 1) == 1;
      d_addr  = W'($urandom_range(0, 255)) << 2;
      d_wdata = W'($urandom);
    end
  endtask

  int n, di, fi;
  logic [W-1:0] prev;

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = W'($urandom);
    mem_arr[4] = 32'h00A0_0093;
    m_reset();

    // Reset state
    repeat (3) step();
    chk("rst_stall", stall, 1'b0);
    rst = 1'b1;
    step();

    // Single fetch, ready on the 3rd cycle of mem_req
    rdy_mode = 2; rdy_n = 3;
    if_req = 1'b1; if_addr = 32'h10;
    n = 0;
    while (!if_valid && n < 20) begin
      step(); n++;
      if (n == 1) begin
        chk("f_maddr", mem_addr, 32'h10);
        chk("f_mwe", mem_we, 1'b0);
      end
    end
    chk("f_latency", n, 4);
    chk("f_rdata", if_rdata, 32'h00A0_0093);
    chk("f_stall_valid", stall, 1'b0);
    if_req = 1'b0;
    step();

    // Simultaneous requests, memory always ready
    rdy_mode = 1;
    if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    n = 0; di = 0; fi = 0;
    while ((di == 0 || fi == 0) && n < 20) begin
      step(); n++;
      if (n == 1) chk("sim_first", mem_addr, 32'h100);
      if (n == 3) chk("sim_second", mem_addr, 32'h20);
      if (d_valid) begin di = n; d_req = 1'b0; end
      if (if_valid) begin fi = n; if_req = 1'b0; end
    end
    chk("sim_dcycle", di, 2);
    chk("sim_icycle", fi, 4);

    // Fetch held while data requests arrive back to back
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    n = 0; di = 0; fi = 0;
    while (di < 4 && n < 60) begin
      step(); n++;
      if (d_valid) begin
        di++;
        d_req = (di < 4); d_addr = 32'h80 + W'(di * 4);
      end
      if (if_valid) begin fi++; if_addr = 32'h40 + W'(fi * 4); end
    end
    chk("burst_d_done", di, 4);
    chk("burst_if_progress", (fi > 0), 1'b1);
    if_req = 1'b0; d_req = 1'b0;
    repeat (3) step();

    // Store then load, random memory latency
    rdy_mode = 0;
    prev = exp_d_rdata;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    n = 0;
    while (!d_valid && n < 60) begin
      step(); n++;
      if (n == 1) begin
        chk("st_we", mem_we, 1'b1);
        chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
      end
    end
    chk("st_done", d_valid, 1'b1);
    chk("st_rdata_keep", d_rdata, prev);
    d_req = 1'b0;
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_wdata = '0;
    n = 0;
    while (!d_valid && n < 60) begin step(); n++; end
    chk("ld_done", d_valid, 1'b1);
    chk("ld_rdata", d_rdata, 32'hDEAD_BEEF);
    d_req = 1'b0;
    step();

    // Asynchronous reset while a load is stuck in flight
    rdy_mode = 3;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    repeat (2) step();
    chk("pre_arst_req", mem_req, 1'b1);
    #2 rst = 1'b0;
    #1;
    m_reset();
    chk("arst_mem_req", mem_req, 1'b0);
    chk("arst_d_valid", d_valid, 1'b0);
    repeat (2) step();
    rst = 1'b1;
    rdy_mode = 1;
    n = 0;
    while (!d_valid && n < 10) begin step(); n++; end
    chk("post_arst_done", d_valid, 1'b1);
    chk("post_arst_rdata", d_rdata, mem_arr[16]);
    d_req = 1'b0;
    step();

    // mem_ready pulses with nothing pending
    rdy_mode = 1;
    repeat (3) begin
      step();
      chk("glitch_if_valid", if_valid, 1'b0);
      chk("glitch_d_valid", d_valid, 1'b0);
    end

    // Random traffic
    rdy_mode = 0;
    repeat (1500) begin
      rand_agents();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
